// File: rtl/write_master.sv
// Avalon-MM write master: drains an internal FIFO into consecutive word addresses
// after a start pulse, then returns a one-cycle done pulse.
module write_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iWM_start,
  input  logic [31:0]           iDest_address,
  input  logic [31:0]           iLength,
  input  logic                  iFifo_write,
  input  logic [DATA_WIDTH-1:0] iFifo_data,
  output logic                  oFifo_full,
  output logic [FIFO_AW:0]      oFifo_used,
  output logic [31:0]           oAddress,
  output logic                  oWrite,
  output logic [DATA_WIDTH-1:0] oWrite_data,
  output logic [3:0]            oByteenable,
  input  logic                  iWait_request,
  output logic                  oBusy,
  output logic                  oWM_done
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  localparam logic [FIFO_AW:0] FullCount = FIFO_DEPTH[FIFO_AW:0];

  state_e state_q, state_d;

  logic [31:0]           addr_q;
  logic [29:0]           words_q;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [FIFO_AW:0]      used_q, used_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic accept;
  logic start_idle;

  assign fifo_empty = (used_q == '0);
  assign fifo_full  = (used_q == FullCount);
  // A push while full is dropped even if the same cycle pops.
  assign push       = iFifo_write & ~fifo_full;
  assign accept     = oWrite & ~iWait_request;
  assign pop        = accept;
  assign start_idle = (state_q == StIdle) & iWM_start;

  assign oFifo_full  = fifo_full;
  assign oFifo_used  = used_q;
  assign oAddress    = addr_q;
  assign oWrite_data = fifo_mem[rd_ptr_q];
  assign oByteenable = 4'hF;

  // State register
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (iWM_start) begin
          state_d = (iLength[31:2] == '0) ? StDone : StWrite;
        end
      end
      StWrite: begin
        if (accept && (words_q == 30'd1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    oWrite   = 1'b0;
    oBusy    = 1'b0;
    oWM_done = 1'b0;
    unique case (state_q)
      StIdle: ;
      StWrite: begin
        oWrite = ~fifo_empty;
        oBusy  = 1'b1;
      end
      StDone: begin
        oBusy    = 1'b1;
        oWM_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Address and remaining-word counter; both move only on an accept so the
  // Avalon address holds steady under waitrequest.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      addr_q  <= '0;
      words_q <= '0;
    end else if (start_idle) begin
      addr_q  <= {iDest_address[31:2], 2'b00};
      words_q <= iLength[31:2];
    end else if (accept) begin
      addr_q  <= addr_q + 32'd4;
      words_q <= words_q - 30'd1;
    end
  end

  always_comb begin
    used_d = used_q;
    if (push && !pop) begin
      used_d = used_q + (FIFO_AW+1)'(1);
    end else if (pop && !push) begin
      used_d = used_q - (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      used_q <= used_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge iClk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= iFifo_data;
    end
  end

endmodule
